// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RISC-V decode stage with 1-entry skid buffer
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imme,
    output logic             out_rs1_en,
    output logic             out_rs2_en,
    output logic             out_rd_we,
    output logic             out_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imme;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    bundle_t     dec;
    bundle_t     out_q, out_d;
    bundle_t     skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        skid_valid_q, skid_valid_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        sgn;
    logic [31:0] imm32;
    logic        ill;
    logic        rs1_en;
    logic        rs2_en;
    logic        rd_we;
    logic        load_bad;
    logic        store_bad;
    logic        accept;
    logic        out_free;

    // Combinational decode of the presented instruction: fields, immediate, usage flags, legality
    always_comb begin
        opcode    = in_instr[6:0];
        funct3    = in_instr[14:12];
        funct7    = in_instr[31:25];
        sgn       = in_instr[31];
        imm32     = 32'd0;
        ill       = 1'b0;
        rs1_en    = 1'b0;
        rs2_en    = 1'b0;
        rd_we     = 1'b0;
        // RV64 adds ld/lwu/sd, so fewer load/store widths are reserved there
        if (XLEN == 64) begin
            load_bad  = (funct3 == 3'b111);
            store_bad = (funct3 >= 3'b100);
        end else begin
            load_bad  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            store_bad = (funct3 >= 3'b011);
        end
        case (opcode)
            OP_R: begin
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                rd_we  = 1'b1;
                if (funct7 == 7'b0100000) begin
                    ill = !((funct3 == 3'b000) || (funct3 == 3'b101));
                end else if (funct7 != 7'b0000000) begin
                    ill = 1'b1;
                end
            end
            OP_I: begin
                imm32  = {{20{sgn}}, in_instr[31:20]};
                rs1_en = 1'b1;
                rd_we  = 1'b1;
            end
            OP_LOAD: begin
                imm32  = {{20{sgn}}, in_instr[31:20]};
                rs1_en = 1'b1;
                rd_we  = 1'b1;
                ill    = load_bad;
            end
            OP_S: begin
                imm32  = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                ill    = store_bad;
            end
            OP_B: begin
                imm32  = {{19{sgn}}, in_instr[31], in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
                rs1_en = 1'b1;
                rs2_en = 1'b1;
                ill    = (funct3[2:1] == 2'b01);
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {in_instr[31:12], 12'd0};
                rd_we = 1'b1;
            end
            OP_JAL: begin
                imm32 = {{11{sgn}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
                rd_we = 1'b1;
            end
            OP_JALR: begin
                imm32  = {{20{sgn}}, in_instr[31:20]};
                rs1_en = 1'b1;
                rd_we  = 1'b1;
                ill    = (funct3 != 3'b000);
            end
            OP_FENCE, OP_SYSTEM: begin
                imm32 = {{20{sgn}}, in_instr[31:20]};
            end
            default: ill = 1'b1;
        endcase
        // Compressed or otherwise non-32-bit encodings are not handled by this stage
        if (in_instr[1:0] != 2'b11) begin
            ill = 1'b1;
        end
        // x0 writes are architecturally discarded, so never request a write port
        if (in_instr[11:7] == 5'd0) begin
            rd_we = 1'b0;
        end
        if (ill) begin
            imm32  = 32'd0;
            rs1_en = 1'b0;
            rs2_en = 1'b0;
            rd_we  = 1'b0;
        end
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = opcode;
        dec.funct3  = funct3;
        dec.funct7  = funct7;
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.rd      = in_instr[11:7];
        dec.imme    = XLEN'($signed(imm32));
        dec.rs1_en  = rs1_en;
        dec.rs2_en  = rs2_en;
        dec.rd_we   = rd_we;
        dec.illegal = ill;
    end

    // in_ready depends only on a flop, so execute backpressure never reaches fetch combinationally
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    // Next-state for output register and skid entry; flush kills everything in flight
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_imme    = out_q.imme;
    assign out_rs1_en  = out_q.rs1_en;
    assign out_rs2_en  = out_q.rs2_en;
    assign out_rd_we   = out_q.rd_we;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - scoreboard bench for id_stage_pipe at XLEN 32 and 64
module tb_id_stage_pipe;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] fld;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [3:0]  fl32;
        logic [3:0]  fl64;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_ready;

    logic        in_ready32, out_valid32, rs1_en32, rs2_en32, rd_we32, ill32;
    logic [31:0] out_pc32, imme32;
    logic [6:0]  opcode32, funct7_32;
    logic [2:0]  funct3_32;
    logic [4:0]  rs1_32, rs2_32, rd32;

    logic        in_ready64, out_valid64, rs1_en64, rs2_en64, rd_we64, ill64;
    logic [31:0] out_pc64;
    logic [63:0] imme64;
    logic [6:0]  opcode64, funct7_64;
    logic [2:0]  funct3_64;
    logic [4:0]  rs1_64, rs2_64, rd64;

    logic [31:0] fld32, fld64;
    logic [3:0]  fl32, fl64;
    assign fld32 = {opcode32, funct3_32, funct7_32, rs1_32, rs2_32, rd32};
    assign fld64 = {opcode64, funct3_64, funct7_64, rs1_64, rs2_64, rd64};
    assign fl32  = {rs1_en32, rs2_en32, rd_we32, ill32};
    assign fl64  = {rs1_en64, rs2_en64, rd_we64, ill64};

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic acc_pend = 1'b0;

    id_stage_pipe #(.XLEN(32), .PC_W(32)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
        .out_pc(out_pc32), .out_opcode(opcode32), .out_funct3(funct3_32), .out_funct7(funct7_32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32), .out_imme(imme32),
        .out_rs1_en(rs1_en32), .out_rs2_en(rs2_en32), .out_rd_we(rd_we32), .out_illegal(ill32)
    );

    id_stage_pipe #(.XLEN(64), .PC_W(32)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
        .out_pc(out_pc64), .out_opcode(opcode64), .out_funct3(funct3_64), .out_funct7(funct7_64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64), .out_imme(imme64),
        .out_rs1_en(rs1_en64), .out_rs2_en(rs2_en64), .out_rd_we(rd_we64), .out_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Keep the low n bits of v and replicate bit n-1 upward
    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        logic [63:0] m;
        logic [63:0] r;
        m = ~64'd0 << n;
        r = v & ~m;
        return r[n-1] ? (r | m) : r;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [63:0] w, imm;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic        r1, r2, wr, bad, b32, b64;
        w = {32'd0, ins};
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        imm = 64'd0; r1 = 0; r2 = 0; wr = 0; bad = 0; b32 = 0; b64 = 0;
        case (op)
            OP_R:      begin r1 = 1; r2 = 1; wr = 1;
                       bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))); end
            OP_I:      begin imm = sext(w >> 20, 12); r1 = 1; wr = 1; end
            OP_FENCE, OP_SYSTEM: imm = sext(w >> 20, 12);
            OP_LOAD:   begin imm = sext(w >> 20, 12); r1 = 1; wr = 1;
                       b32 = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); b64 = (f3 == 3'd7); end
            OP_JALR:   begin imm = sext(w >> 20, 12); r1 = 1; wr = 1; bad = (f3 != 3'd0); end
            OP_S:      begin imm = sext(((w >> 25) << 5) | ((w >> 7) & 64'd31), 12); r1 = 1; r2 = 1;
                       b32 = (f3 >= 3'd3); b64 = (f3 >= 3'd4); end
            OP_B:      begin imm = sext((((w >> 31) & 64'd1) << 12) | (((w >> 7) & 64'd1) << 11) |
                                        (((w >> 25) & 64'd63) << 5) | (((w >> 8) & 64'd15) << 1), 13);
                       r1 = 1; r2 = 1; bad = (f3 == 3'd2 || f3 == 3'd3); end
            OP_LUI, OP_AUIPC: begin imm = sext(w & 64'hFFFFF000, 32); wr = 1; end
            OP_JAL:    begin imm = sext((((w >> 31) & 64'd1) << 20) | (((w >> 12) & 64'd255) << 12) |
                                        (((w >> 20) & 64'd1) << 11) | (((w >> 21) & 64'd1023) << 1), 21);
                       wr = 1; end
            default:   bad = 1;
        endcase
        if (ins[1:0] != 2'b11) bad = 1;
        if (ins[11:7] == 5'd0) wr = 0;
        e.pc    = pc;
        e.fld   = {ins[6:0], ins[14:12], ins[31:25], ins[19:15], ins[24:20], ins[11:7]};
        e.fl32  = (bad || b32) ? 4'b0001 : {r1, r2, wr, 1'b0};
        e.fl64  = (bad || b64) ? 4'b0001 : {r1, r2, wr, 1'b0};
        e.imm32 = (bad || b32) ? 32'd0 : imm[31:0];
        e.imm64 = (bad || b64) ? 64'd0 : imm;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [11];
        ops = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM};
        r = $urandom();
        if ($urandom_range(0, 11) != 0) r[6:0] = ops[$urandom_range(0, 10)];
        if (r[6:0] == OP_R && $urandom_range(0, 3) != 0) r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        if (r[6:0] == OP_JALR && $urandom_range(0, 1) != 0) r[14:12] = 3'd0;
        return r;
    endfunction

    // Observe the input handshake mid-cycle; the accepted bundle is queued at the edge that takes it
    always @(negedge clk) acc_pend = !rst && !flush && in_valid && in_ready32;
    always @(posedge clk) if (acc_pend) sb.push_back(model(in_instr, in_pc));

    // Monitor: occupancy vs. scoreboard, then compare whatever the DUTs hand to execute
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("out_valid32_occupancy", out_valid32, sb.size() > 0);
            chk("out_valid64_occupancy", out_valid64, sb.size() > 0);
            chk("in_ready32_occupancy", in_ready32, sb.size() < 2);
            chk("in_ready64_occupancy", in_ready64, sb.size() < 2);
        end
        if (rst || flush) begin
            sb.delete();
        end else if (out_valid32 && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pc32", out_pc32, e.pc);
                chk("fields32", fld32, e.fld);
                chk("imm32", imme32, e.imm32);
                chk("flags32", fl32, e.fl32);
                chk("pc64", out_pc64, e.pc);
                chk("fields64", fld64, e.fld);
                chk("imm64", imme64, e.imm64);
                chk("flags64", fl64, e.fl64);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {out_valid32, out_valid64}, 2'b00);
        chk({tag, "_in_ready"}, {in_ready32, in_ready64}, 2'b11);
        chk({tag, "_pc"}, {out_pc32, out_pc64}, 64'd0);
        chk({tag, "_fields"}, {fld32, fld64}, 64'd0);
        chk({tag, "_imm"}, imme64 | {32'd0, imme32}, 64'd0);
        chk({tag, "_flags"}, {fl32, fl64}, 8'd0);
    endtask

    task automatic direct(input string tag, input logic [31:0] ins, input logic [31:0] i32,
                          input logic [63:0] i64, input logic [3:0] f32e, input logic [3:0] f64e);
        in_valid = 1; in_instr = ins; in_pc = $urandom(); out_ready = 1; flush = 0;
        step();
        in_valid = 0;
        chk({tag, "_valid"}, {out_valid32, out_valid64}, 2'b11);
        chk({tag, "_imm32"}, imme32, i32);
        chk({tag, "_imm64"}, imme64, i64);
        chk({tag, "_flags32"}, fl32, f32e);
        chk({tag, "_flags64"}, fl64, f64e);
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int sent, got, hold;
        logic seen_first, acc;
        rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        repeat (2) step();
        rst = 0;
        check_zero("reset");

        direct("addi", 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'b1010, 4'b1010);
        direct("beq", 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 4'b1100, 4'b1100);
        direct("lui", 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 4'b0010, 4'b0010);
        direct("ld", 32'h0000B083, 32'h0, 64'h0, 4'b0001, 4'b1010);
        direct("zero", 32'h00000000, 32'h0, 64'h0, 4'b0001, 4'b0001);
        direct("bf3_010", 32'h0000A063, 32'h0, 64'h0, 4'b0001, 4'b0001);

        sent = 0; got = 0; hold = 0; seen_first = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (out_valid32 && !seen_first) begin seen_first = 1; hold = 3; end
            if (seen_first && hold > 0) begin out_ready = 0; hold--; end
            else out_ready = seen_first;
            in_valid = (sent < 4) && in_ready32;
            in_pc    = sent * 4;
            in_instr = 32'h00100093 | (32'(sent) << 20);
            if (out_ready) chk("bp_no_bubble", out_valid32, 1);
            if (out_valid32 && out_ready) begin
                chk("bp_order", out_pc32, got * 4);
                got++;
            end
            acc = in_valid && in_ready32;
            step();
            if (acc) begin
                sent++;
                if (sent == 2) chk("bp_in_ready_drop", in_ready32, 0);
            end
        end
        in_valid = 0;
        chk("bp_all_out", got, 4);

        out_ready = 0; in_valid = 1; in_instr = rand_instr(); in_pc = 32'h100;
        step();
        in_instr = rand_instr(); in_pc = 32'h104;
        step();
        chk("flush_skid_full", in_ready32, 0);
        in_instr = rand_instr(); in_pc = 32'h108; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush_valid", {out_valid32, out_valid64}, 2'b00);
        chk("flush_in_ready", {in_ready32, in_ready64}, 2'b11);
        out_ready = 1;
        repeat (3) step();
        in_valid = 1; in_instr = 32'hFFF00093; in_pc = 32'h200; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush_same_cycle_accept", {out_valid32, out_valid64}, 2'b00);
        repeat (2) step();

        out_ready = 0; in_valid = 1;
        repeat (3) begin in_instr = rand_instr(); in_pc = $urandom(); step(); end
        in_valid = 0; rst = 1;
        step();
        rst = 0;
        check_zero("mid_reset");

        for (int c = 0; c < 800; c++) begin
            in_valid  = $urandom_range(0, 9) < 7;
            in_instr  = rand_instr();
            in_pc     = $urandom();
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 49) == 0;
            step();
        end
        in_valid = 0; flush = 0; out_ready = 1;
        for (int c = 0; c < 10 && sb.size() != 0; c++) step();
        step();
        chk("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
